// File: rtl/sccb_camera_configurator_pkg.sv
// Shared types and constants for the SCCB camera bring-up controller.
package cam_cfg_pkg;

  typedef enum logic [3:0] {
    PWR_DN     = 4'd0,
    RST_ASSERT = 4'd1,
    BOOT       = 4'd2,
    FETCH      = 4'd3,
    DECODE     = 4'd4,
    ISSUE      = 4'd5,
    WAIT_ACK   = 4'd6,
    DELAY      = 4'd7,
    DONE       = 4'd8,
    ERROR      = 4'd9
  } cfg_state_t;

  // Table entry that terminates the walk.
  localparam logic [15:0] END_MARKER = 16'hFFFF;
  // High byte that turns an entry into a millisecond delay.
  localparam logic [7:0]  DELAY_TAG  = 8'hF0;

  // Larger of two integers; used to size shared counters.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sccb_camera_configurator_if.sv
// Handshake between the configurator and the SCCB byte engine.
interface sccb_camera_configurator_if;
  logic       sccb_start;
  logic [7:0] sccb_id;
  logic [7:0] sccb_reg;
  logic [7:0] sccb_val;
  logic       sccb_busy;
  logic       sccb_done;
  logic       sccb_nack;

  modport master (
    output sccb_start, sccb_id, sccb_reg, sccb_val,
    input  sccb_busy, sccb_done, sccb_nack
  );

  modport slave (
    input  sccb_start, sccb_id, sccb_reg, sccb_val,
    output sccb_busy, sccb_done, sccb_nack
  );
endinterface

// File: rtl/sccb_camera_configurator_xclk.sv
// Free-running camera master clock divider; only rst stops it.
module cam_xclk_gen #(
  parameter int XCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic xclk
);
  localparam int HALF = XCLK_DIV / 2;
  localparam int W    = (HALF > 1) ? $clog2(HALF) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         xclk_q, xclk_d;

  // Toggle xclk every HALF clk edges.
  always_comb begin
    cnt_d  = cnt_q;
    xclk_d = xclk_q;
    if (cnt_q == W'(HALF - 1)) begin
      cnt_d  = '0;
      xclk_d = ~xclk_q;
    end else begin
      cnt_d  = cnt_q + W'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      xclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      xclk_q <= xclk_d;
    end
  end

  assign xclk = xclk_q;
endmodule

// File: rtl/sccb_camera_configurator.sv
// Camera bring-up: power sequencing, then one SCCB write per ROM table entry,
// with delay/end markers, NACK retries and a restart path that skips power-up.
module sccb_camera_configurator
  import cam_cfg_pkg::*;
#(
  parameter logic [7:0] CAMERA_ID     = 8'h42,
  parameter int         NUM_REGS      = 256,
  parameter int         XCLK_DIV      = 2,
  parameter int         PWDN_CYCLES   = 1000,
  parameter int         RESET_CYCLES  = 1000,
  parameter int         BOOT_CYCLES   = 100000,
  parameter int         CYCLES_PER_MS = 100000,
  parameter int         MAX_RETRY     = 3,
  localparam int        ADDR_W        = $clog2(NUM_REGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [15:0]          rom_data,
  sccb_camera_configurator_if.master sccb,
  output logic                 xclk,
  output logic                 pwdn,
  output logic                 cam_reset_n,
  output logic                 config_finished,
  output logic                 config_error,
  output logic [ADDR_W-1:0]    error_addr
);
  // One counter serves the power phases and the per-ms tick; ms count is separate,
  // so a 255 ms delay needs only CYCLES_PER_MS range here.
  localparam int CNT_MAX = max2(max2(PWDN_CYCLES, RESET_CYCLES), max2(BOOT_CYCLES, CYCLES_PER_MS));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  cfg_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          ms_q, ms_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   error_addr_q, error_addr_d;
  logic [7:0]          reg_q, reg_d, val_q, val_d;
  logic                start_q, start_d;
  logic                pwdn_q, pwdn_d;
  logic                cam_reset_n_q, cam_reset_n_d;
  logic                finished_q, finished_d;
  logic                error_q, error_d;

  cam_xclk_gen #(.XCLK_DIV(XCLK_DIV)) u_xclk (
    .clk  (clk),
    .rst  (rst),
    .xclk (xclk)
  );

  // Next-state logic for the sequencer, table walk and retry bookkeeping.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ms_d          = ms_q;
    retry_d       = retry_q;
    rom_addr_d    = rom_addr_q;
    error_addr_d  = error_addr_q;
    reg_d         = reg_q;
    val_d         = val_q;
    start_d       = 1'b0;
    pwdn_d        = pwdn_q;
    cam_reset_n_d = cam_reset_n_q;
    case (state_q)
      PWR_DN: begin
        if (cnt_q == CNT_W'(PWDN_CYCLES - 1)) begin
          cnt_d   = '0;
          pwdn_d  = 1'b0;
          state_d = RST_ASSERT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RST_ASSERT: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          cnt_d         = '0;
          cam_reset_n_d = 1'b1;
          state_d       = BOOT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BOOT: begin
        if (cnt_q == CNT_W'(BOOT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FETCH: begin
        // ROM registers rom_addr this cycle; data is usable in DECODE.
        state_d = DECODE;
      end
      DECODE: begin
        if ((rom_addr_q == ADDR_W'(NUM_REGS)) || (rom_data == END_MARKER)) begin
          state_d = DONE;
        end else if (rom_data[15:8] == DELAY_TAG) begin
          ms_d    = rom_data[7:0];
          cnt_d   = '0;
          state_d = DELAY;
        end else begin
          reg_d   = rom_data[15:8];
          val_d   = rom_data[7:0];
          state_d = ISSUE;
        end
      end
      DELAY: begin
        // A zero-length delay still spends this one cycle here.
        if ((ms_q == 8'd0) ||
            ((ms_q == 8'd1) && (cnt_q == CNT_W'(CYCLES_PER_MS - 1)))) begin
          cnt_d      = '0;
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          state_d    = FETCH;
        end else if (cnt_q == CNT_W'(CYCLES_PER_MS - 1)) begin
          cnt_d = '0;
          ms_d  = ms_q - 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ISSUE: begin
        if (!sccb.sccb_busy) begin
          start_d = 1'b1;
          state_d = WAIT_ACK;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_ACK: begin
        if (sccb.sccb_done) begin
          if (!sccb.sccb_nack) begin
            retry_d    = '0;
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = FETCH;
          end else if (retry_q != RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ISSUE;
          end else begin
            error_addr_d = rom_addr_q;
            state_d      = ERROR;
          end
        end else begin
          state_d = WAIT_ACK;
        end
      end
      DONE, ERROR: begin
        if (restart) begin
          rom_addr_d   = '0;
          retry_d      = '0;
          error_addr_d = '0;
          state_d      = FETCH;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = PWR_DN;
      end
    endcase
    finished_d = (state_d == DONE);
    error_d    = (state_d == ERROR);
  end

  // State and output registers; rst returns everything to power-down.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PWR_DN;
      cnt_q         <= '0;
      ms_q          <= 8'd0;
      retry_q       <= '0;
      rom_addr_q    <= '0;
      error_addr_q  <= '0;
      reg_q         <= 8'd0;
      val_q         <= 8'd0;
      start_q       <= 1'b0;
      pwdn_q        <= 1'b1;
      cam_reset_n_q <= 1'b0;
      finished_q    <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ms_q          <= ms_d;
      retry_q       <= retry_d;
      rom_addr_q    <= rom_addr_d;
      error_addr_q  <= error_addr_d;
      reg_q         <= reg_d;
      val_q         <= val_d;
      start_q       <= start_d;
      pwdn_q        <= pwdn_d;
      cam_reset_n_q <= cam_reset_n_d;
      finished_q    <= finished_d;
      error_q       <= error_d;
    end
  end

  assign rom_addr        = rom_addr_q;
  assign error_addr      = error_addr_q;
  assign pwdn            = pwdn_q;
  assign cam_reset_n     = cam_reset_n_q;
  assign config_finished = finished_q;
  assign config_error    = error_q;
  assign sccb.sccb_start = start_q;
  assign sccb.sccb_id    = CAMERA_ID;
  assign sccb.sccb_reg   = reg_q;
  assign sccb.sccb_val   = val_q;
endmodule

// File: tb/tb_sccb_camera_configurator.sv
// Scoreboard bench: expected writes are queued with each table, a monitor pops
// and compares on every sccb_start; an engine model ACKs/NACKs per plan.
module tb_sccb_camera_configurator;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              restart = 1'b0;
  logic [ADDR_W-1:0] rom_addr, error_addr;
  logic [15:0]       rom_data;
  logic              xclk, pwdn, cam_reset_n, config_finished, config_error;

  logic [15:0] rom_mem [0:15];
  int          nack_plan [0:15];
  logic [15:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          start_cnt = 0;

  sccb_camera_configurator_if sif ();

  sccb_camera_configurator #(
    .CAMERA_ID(8'h42), .NUM_REGS(NUM_REGS), .XCLK_DIV(4), .PWDN_CYCLES(4),
    .RESET_CYCLES(4), .BOOT_CYCLES(8), .CYCLES_PER_MS(10), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb(sif), .xclk(xclk), .pwdn(pwdn), .cam_reset_n(cam_reset_n),
    .config_finished(config_finished), .config_error(config_error), .error_addr(error_addr)
  );

  always #5 clk = ~clk;

  // Synchronous table ROM: data one cycle after address.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // SCCB engine model: busy 4 cycles, then done; NACKs the first nack_plan[idx] attempts.
  logic eng_busy, eng_done, eng_nack, eng_nk;
  int   eng_timer, eng_att, eng_last;
  assign sif.sccb_busy = eng_busy;
  assign sif.sccb_done = eng_done;
  assign sif.sccb_nack = eng_nack;
  always @(posedge clk) begin
    if (rst) begin
      eng_busy <= 1'b0; eng_done <= 1'b0; eng_nack <= 1'b0; eng_nk <= 1'b0;
      eng_timer <= 0; eng_att <= 0; eng_last <= -1;
    end else begin
      eng_done <= 1'b0;
      eng_nack <= 1'b0;
      if (sif.sccb_start) begin
        eng_busy  <= 1'b1;
        eng_timer <= 3;
        eng_last  <= int'(rom_addr);
        if (int'(rom_addr) == eng_last) begin
          eng_att <= eng_att + 1;
          eng_nk  <= ((eng_att + 1) < nack_plan[rom_addr]);
        end else begin
          eng_att <= 0;
          eng_nk  <= (0 < nack_plan[rom_addr]);
        end
      end else if (eng_busy) begin
        if (eng_timer == 0) begin
          eng_busy <= 1'b0;
          eng_done <= 1'b1;
          eng_nack <= eng_nk;
        end else begin
          eng_timer <= eng_timer - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [15:0] cur;
    cur = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst && sif.sccb_start) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_start: got reg/val 0x%0h, want no write", {sif.sccb_reg, sif.sccb_val});
        end else begin
          cur = exp_q.pop_front();
          check("write_regval", 32'({sif.sccb_reg, sif.sccb_val}), 32'(cur));
        end
        check("write_id", 32'(sif.sccb_id), 32'h42);
      end
      if (!rst && sif.sccb_done) check("hold_regval", 32'({sif.sccb_reg, sif.sccb_val}), 32'(cur));
    end
  endtask

  task automatic wait_term(input string name);
    int n, glitch;
    n = 0; glitch = 0;
    while (!(config_finished || config_error) && n < 3000) begin
      @(negedge clk);
      n++;
      if (pwdn !== 1'b0 || cam_reset_n !== 1'b1) glitch++;
    end
    check({name, "_reached_end"}, 32'(n < 3000), 32'd1);
    check({name, "_power_quiet"}, 32'(glitch), 32'd0);
  endtask

  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  initial begin
    int s0, n;
    logic got;
    for (int i = 0; i < 16; i++) begin rom_mem[i] = 16'hFFFF; nack_plan[i] = 0; end
    fork monitor_loop(); join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({xclk, pwdn, cam_reset_n, sif.sccb_start, config_finished, config_error}), 32'b010000);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_error_addr", 32'(error_addr), 32'd0);

    // Power sequence, xclk, first write timing; table {1280,1204,FFFF}
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1204; rom_mem[2] = 16'hFFFF;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1204);
    rst = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k <= 8) check($sformatf("xclk_k%0d", k), 32'(xclk), 32'((k / 2) % 2));
      if (k == 3 || k == 4) check($sformatf("pwdn_k%0d", k), 32'(pwdn), 32'(k < 4));
      if (k == 7 || k == 8) check($sformatf("cam_reset_n_k%0d", k), 32'(cam_reset_n), 32'(k >= 8));
      if (k == 18 || k == 19) check($sformatf("first_start_k%0d", k), 32'(sif.sccb_start), 32'(k == 19));
    end
    wait_term("tbl_a");
    check("a_finished", 32'({config_finished, config_error}), 32'b10);
    check("a_rom_addr", 32'(rom_addr), 32'd2);
    check("a_starts", 32'(start_cnt), 32'd2);

    // Delay entry: {F003,1180,FFFF}; start lands 35 edges after restart edge
    rom_mem[0] = 16'hF003; rom_mem[1] = 16'h1180; rom_mem[2] = 16'hFFFF;
    exp_q.push_back(16'h1180);
    s0 = start_cnt;
    @(negedge clk); restart = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        restart = 1'b0;
        check("b_finished_cleared", 32'(config_finished), 32'd0);
      end
      got = sif.sccb_start;
    end
    check("b_delay_edges", 32'(n), 32'd36);
    wait_term("tbl_b");
    check("b_rom_addr", 32'(rom_addr), 32'd2);
    check("b_starts", 32'(start_cnt - s0), 32'd1);

    // NACK twice then ACK: {3A04,1111,FFFF}
    rom_mem[0] = 16'h3A04; rom_mem[1] = 16'h1111; rom_mem[2] = 16'hFFFF;
    nack_plan[0] = 2;
    repeat (3) exp_q.push_back(16'h3A04);
    exp_q.push_back(16'h1111);
    s0 = start_cnt;
    pulse_restart();
    wait_term("tbl_c");
    check("c_finished", 32'({config_finished, config_error}), 32'b10);
    check("c_starts", 32'(start_cnt - s0), 32'd4);
    nack_plan[0] = 0;

    // Entry 5 NACKed on every attempt -> ERROR with error_addr=5
    for (int i = 0; i < 7; i++) rom_mem[i] = {8'(i + 1), 8'(i + 1)};
    rom_mem[7] = 16'hFFFF;
    nack_plan[5] = 4;
    for (int i = 0; i < 5; i++) exp_q.push_back({8'(i + 1), 8'(i + 1)});
    repeat (4) exp_q.push_back(16'h0606);
    s0 = start_cnt;
    pulse_restart();
    wait_term("tbl_d");
    check("d_error", 32'({config_finished, config_error}), 32'b01);
    check("d_error_addr", 32'(error_addr), 32'd5);
    check("d_starts", 32'(start_cnt - s0), 32'd9);
    nack_plan[5] = 0;

    // Restart out of ERROR clears status and reruns from 0
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFFF;
    exp_q.push_back(16'h1280);
    pulse_restart();
    wait_term("tbl_d2");
    check("d2_status", 32'({config_finished, config_error}), 32'b10);
    check("d2_error_addr", 32'(error_addr), 32'd0);

    // Full table with no end marker: stops at rom_addr == NUM_REGS
    for (int i = 0; i < 8; i++) begin
      rom_mem[i] = {8'(i + 1), 8'(8'h80 + i)};
      exp_q.push_back({8'(i + 1), 8'(8'h80 + i)});
    end
    s0 = start_cnt;
    pulse_restart();
    wait_term("tbl_e");
    check("e_finished", 32'({config_finished, config_error}), 32'b10);
    check("e_rom_addr", 32'(rom_addr), 32'd8);
    check("e_starts", 32'(start_cnt - s0), 32'd8);

    // rst during a write: outputs at reset values one edge later
    exp_q.push_back(16'h0180);
    pulse_restart();
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      got = sif.sccb_start;
    end
    check("f_write_started", 32'(got), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("f_rst_outs", 32'({xclk, pwdn, cam_reset_n, sif.sccb_start, config_finished, config_error}), 32'b010000);
    check("f_rst_addrs", 32'({rom_addr, error_addr}), 32'd0);
    repeat (10) @(negedge clk);
    check("f_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
